// File: rtl/tutorial_ctrl_pkg.sv
// Shared definitions for the tutorial DataPath micro-sequencer: opcodes,
// FSM state encoding and the bus/load enable bundle.
package tutorial_ctrl_pkg;

    localparam int IMM_W_DEF = 8;
    localparam int OP_W_DEF  = 3;

    localparam int unsigned OP_NOP      = 0;
    localparam int unsigned OP_LDI_A    = 1;
    localparam int unsigned OP_ADDI_B_A = 2;
    localparam int unsigned OP_MV_B_Z   = 3;
    localparam int unsigned OP_ADDI_A_A = 4;
    localparam int unsigned OP_ADDI_B_B = 5;
    localparam int unsigned OP_MV_A_Z   = 6;
    localparam int unsigned OP_ILLEGAL  = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_T0   = 2'd1,
        ST_T1   = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    typedef struct packed {
        logic ra_out;
        logic rb_out;
        logic rz_out;
        logic ra_in;
        logic rb_in;
        logic rz_in;
    } ctrl_en_t;

    // Add-immediate ops go through Z, so they take a second step to write back.
    function automatic logic is_two_step(input int unsigned op);
        return (op == OP_ADDI_B_A) || (op == OP_ADDI_A_A) || (op == OP_ADDI_B_B);
    endfunction

endpackage

// File: rtl/tutorial_step_decode.sv
// Combinational T-step decoder: maps (state, latched opcode, immediate) to
// the bus-drive/load enables, immediates and done/err flags for that step.
module tutorial_step_decode
    import tutorial_ctrl_pkg::*;
#(
    parameter int IMM_W = IMM_W_DEF,
    parameter int OP_W  = OP_W_DEF
) (
    input  state_t             state,
    input  logic [OP_W-1:0]    op,
    input  logic [IMM_W-1:0]   imm,
    output ctrl_en_t           en,
    output logic [IMM_W-1:0]   add_imm,
    output logic [IMM_W-1:0]   rega_imm,
    output logic               done,
    output logic               err
);

    always_comb begin
        en       = '0;
        add_imm  = '0;
        rega_imm = '0;
        done     = 1'b0;
        err      = 1'b0;
        unique case (state)
            ST_T0: begin
                case (op)
                    OP_W'(OP_NOP): begin
                        done = 1'b1;
                    end
                    OP_W'(OP_LDI_A): begin
                        rega_imm = imm;
                        en.ra_in = 1'b1;
                        done     = 1'b1;
                    end
                    OP_W'(OP_ADDI_B_A), OP_W'(OP_ADDI_A_A): begin
                        en.ra_out = 1'b1;
                        add_imm   = imm;
                        en.rz_in  = 1'b1;
                    end
                    OP_W'(OP_ADDI_B_B): begin
                        en.rb_out = 1'b1;
                        add_imm   = imm;
                        en.rz_in  = 1'b1;
                    end
                    OP_W'(OP_MV_B_Z): begin
                        en.rz_out = 1'b1;
                        en.rb_in  = 1'b1;
                        done      = 1'b1;
                    end
                    OP_W'(OP_MV_A_Z): begin
                        en.rz_out = 1'b1;
                        en.ra_in  = 1'b1;
                        done      = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T1: begin
                // Write-back of the adder result held in Z.
                en.rz_out = 1'b1;
                done      = 1'b1;
                if (op == OP_W'(OP_ADDI_A_A)) begin
                    en.ra_in = 1'b1;
                end else begin
                    en.rb_in = 1'b1;
                end
            end
            ST_ERR: begin
                err = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tutorial_control_unit.sv
// Hardwired micro-sequencer: accepts one macro-instruction over start/busy and
// replays it as registered one-hot control steps for the tutorial DataPath.
module tutorial_control_unit
    import tutorial_ctrl_pkg::*;
#(
    parameter int IMM_W = IMM_W_DEF,
    parameter int OP_W  = OP_W_DEF
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [OP_W-1:0]    instr_op,
    input  logic [IMM_W-1:0]   instr_imm,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               RAout,
    output logic               RBout,
    output logic               RZout,
    output logic               RAin,
    output logic               RBin,
    output logic               RZin,
    output logic [IMM_W-1:0]   AddImmediate,
    output logic [IMM_W-1:0]   RegisterAImmediate
);

    state_t             state_q;
    state_t             state_d;
    logic [OP_W-1:0]    op_q;
    logic [OP_W-1:0]    op_d;
    logic [IMM_W-1:0]   imm_q;
    logic [IMM_W-1:0]   imm_d;
    logic               accept;

    ctrl_en_t           en_p0;
    logic [IMM_W-1:0]   add_imm_p0;
    logic [IMM_W-1:0]   rega_imm_p0;
    logic               done_p0;
    logic               err_p0;

    always_comb begin
        state_d = state_q;
        accept  = (state_q == ST_IDLE) && start;
        op_d    = accept ? instr_op  : op_q;
        imm_d   = accept ? instr_imm : imm_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (instr_op == OP_W'(OP_ILLEGAL)) ? ST_ERR : ST_T0;
                end
            end
            ST_T0:   state_d = is_two_step(32'(op_q)) ? ST_T1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Decode the step about to be entered so every output comes straight from a flop.
    tutorial_step_decode #(
        .IMM_W (IMM_W),
        .OP_W  (OP_W)
    ) u_step_decode (
        .state    (state_d),
        .op       (op_d),
        .imm      (imm_d),
        .en       (en_p0),
        .add_imm  (add_imm_p0),
        .rega_imm (rega_imm_p0),
        .done     (done_p0),
        .err      (err_p0)
    );

    // Stage p0 -> output registers
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q            <= ST_IDLE;
            busy               <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
            RAout              <= 1'b0;
            RBout              <= 1'b0;
            RZout              <= 1'b0;
            RAin               <= 1'b0;
            RBin               <= 1'b0;
            RZin               <= 1'b0;
            AddImmediate       <= '0;
            RegisterAImmediate <= '0;
        end else begin
            state_q            <= state_d;
            busy               <= (state_d != ST_IDLE);
            done               <= done_p0;
            err                <= err_p0;
            RAout              <= en_p0.ra_out;
            RBout              <= en_p0.rb_out;
            RZout              <= en_p0.rz_out;
            RAin               <= en_p0.ra_in;
            RBin               <= en_p0.rb_in;
            RZin               <= en_p0.rz_in;
            AddImmediate       <= add_imm_p0;
            RegisterAImmediate <= rega_imm_p0;
        end
    end

    // The instruction latch only matters once a step is in flight, so it needs no reset.
    always_ff @(posedge clock) begin
        op_q  <= op_d;
        imm_q <= imm_d;
    end

endmodule

// File: tb/tb_tutorial_control_unit.sv
// Bench for tutorial_control_unit: directed vector table, then random traffic
// checked against a step-queue reference model.
module tb_tutorial_control_unit;

    logic       clock = 1'b0;
    logic       clear;
    logic       start;
    logic [2:0] instr_op;
    logic [7:0] instr_imm;
    logic       busy, done, err;
    logic       RAout, RBout, RZout, RAin, RBin, RZin;
    logic [7:0] AddImmediate, RegisterAImmediate;

    tutorial_control_unit #(.IMM_W(8), .OP_W(3)) dut (
        .clock              (clock),
        .clear              (clear),
        .start              (start),
        .instr_op           (instr_op),
        .instr_imm          (instr_imm),
        .busy               (busy),
        .done               (done),
        .err                (err),
        .RAout              (RAout),
        .RBout              (RBout),
        .RZout              (RZout),
        .RAin               (RAin),
        .RBin               (RBin),
        .RZin               (RZin),
        .AddImmediate       (AddImmediate),
        .RegisterAImmediate (RegisterAImmediate)
    );

    always #5 clock = ~clock;

    // en bits: RAout RBout RZout RAin RBin RZin
    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic [5:0] en;
        logic [7:0] add_imm;
        logic [7:0] rega_imm;
    } out_t;

    typedef struct {
        logic       clr;
        logic       st;
        logic [2:0] op;
        logic [7:0] imm;
        out_t       exp;
        string      name;
    } vec_t;

    localparam int RA = 0;
    localparam int RB = 1;
    localparam int RZ = 2;

    vec_t vecs[$];
    out_t exp_q[$];
    bit   model_busy;
    int   n_checks;
    int   n_fail;

    function automatic out_t mk(bit b, bit d, bit e, bit [5:0] en, bit [7:0] ai, bit [7:0] ri);
        out_t o;
        o.busy     = b;
        o.done     = d;
        o.err      = e;
        o.en       = en;
        o.add_imm  = ai;
        o.rega_imm = ri;
        return o;
    endfunction

    function automatic bit [5:0] en_bits(int src, int dst);
        bit [5:0] b = '0;
        case (src)
            RA: b[5] = 1'b1;
            RB: b[4] = 1'b1;
            RZ: b[3] = 1'b1;
            default: ;
        endcase
        case (dst)
            RA: b[2] = 1'b1;
            RB: b[1] = 1'b1;
            RZ: b[0] = 1'b1;
            default: ;
        endcase
        return b;
    endfunction

    function automatic out_t actual();
        return {busy, done, err, RAout, RBout, RZout, RAin, RBin, RZin,
                AddImmediate, RegisterAImmediate};
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = actual();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input bit clr, input bit st, input bit [2:0] op,
                           input bit [7:0] imm, input out_t exp, input string name);
        vec_t v;
        v.clr  = clr;
        v.st   = st;
        v.op   = op;
        v.imm  = imm;
        v.exp  = exp;
        v.name = name;
        vecs.push_back(v);
    endtask

    // Reference model: an accepted instruction becomes a list of expected steps.
    task automatic model_push(input bit [2:0] op, input bit [7:0] imm);
        int src;
        int dst;
        case (op)
            3'd0: exp_q.push_back(mk(1, 1, 0, 6'b0, 8'h00, 8'h00));
            3'd1: exp_q.push_back(mk(1, 1, 0, en_bits(-1, RA), 8'h00, imm));
            3'd2, 3'd4, 3'd5: begin
                src = (op == 3'd5) ? RB : RA;
                dst = (op == 3'd4) ? RA : RB;
                exp_q.push_back(mk(1, 0, 0, en_bits(src, RZ), imm, 8'h00));
                exp_q.push_back(mk(1, 1, 0, en_bits(RZ, dst), 8'h00, 8'h00));
            end
            3'd3: exp_q.push_back(mk(1, 1, 0, en_bits(RZ, RB), 8'h00, 8'h00));
            3'd6: exp_q.push_back(mk(1, 1, 0, en_bits(RZ, RA), 8'h00, 8'h00));
            default: exp_q.push_back(mk(1, 0, 1, 6'b0, 8'h00, 8'h00));
        endcase
    endtask

    task automatic model_edge(input bit clr, input bit st, input bit [2:0] op,
                              input bit [7:0] imm, output out_t e);
        if (clr) begin
            exp_q.delete();
            model_busy = 1'b0;
            e = '0;
        end else begin
            if (st && !model_busy) model_push(op, imm);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                model_busy = 1'b1;
            end else begin
                e = '0;
                model_busy = 1'b0;
            end
        end
    endtask

    task automatic drive(input bit clr, input bit st, input bit [2:0] op, input bit [7:0] imm);
        clear     = clr;
        start     = st;
        instr_op  = op;
        instr_imm = imm;
        @(posedge clock);
        #1;
    endtask

    initial begin
        out_t e;
        bit       r_clr;
        bit       r_st;
        bit [2:0] r_op;
        bit [7:0] r_imm;

        n_checks   = 0;
        n_fail     = 0;
        model_busy = 1'b0;
        clear      = 1'b1;
        start      = 1'b0;
        instr_op   = 3'd0;
        instr_imm  = 8'h00;

        add_vec(1, 0, 3'd0, 8'h00, mk(0, 0, 0, 6'b000000, 8'h00, 8'h00), "reset");
        add_vec(0, 1, 3'd1, 8'h05, mk(1, 1, 0, 6'b000100, 8'h00, 8'h05), "ldi5_t0");
        add_vec(0, 0, 3'd0, 8'h00, mk(0, 0, 0, 6'b000000, 8'h00, 8'h00), "ldi5_idle");
        add_vec(0, 1, 3'd2, 8'h05, mk(1, 0, 0, 6'b100001, 8'h05, 8'h00), "addiba_t0");
        add_vec(0, 0, 3'd0, 8'h00, mk(1, 1, 0, 6'b001010, 8'h00, 8'h00), "addiba_t1");
        add_vec(0, 0, 3'd0, 8'h00, mk(0, 0, 0, 6'b000000, 8'h00, 8'h00), "addiba_idle");
        add_vec(0, 1, 3'd1, 8'h03, mk(1, 1, 0, 6'b000100, 8'h00, 8'h03), "b2b_ldi3");
        add_vec(0, 1, 3'd3, 8'h00, mk(0, 0, 0, 6'b000000, 8'h00, 8'h00), "b2b_ignored");
        add_vec(0, 1, 3'd3, 8'h00, mk(1, 1, 0, 6'b001010, 8'h00, 8'h00), "b2b_mvbz");
        add_vec(0, 0, 3'd0, 8'h00, mk(0, 0, 0, 6'b000000, 8'h00, 8'h00), "b2b_idle");
        add_vec(0, 1, 3'd7, 8'hFF, mk(1, 0, 1, 6'b000000, 8'h00, 8'h00), "illegal_err");
        add_vec(0, 0, 3'd0, 8'h00, mk(0, 0, 0, 6'b000000, 8'h00, 8'h00), "illegal_idle");
        add_vec(0, 1, 3'd4, 8'h09, mk(1, 0, 0, 6'b100001, 8'h09, 8'h00), "addiaa_t0");
        add_vec(1, 0, 3'd0, 8'h00, mk(0, 0, 0, 6'b000000, 8'h00, 8'h00), "clear_mid");
        add_vec(0, 0, 3'd0, 8'h00, mk(0, 0, 0, 6'b000000, 8'h00, 8'h00), "clear_no_t1");
        add_vec(0, 1, 3'd1, 8'h07, mk(1, 1, 0, 6'b000100, 8'h00, 8'h07), "ldi7_after_clear");
        add_vec(0, 0, 3'd0, 8'h00, mk(0, 0, 0, 6'b000000, 8'h00, 8'h00), "ldi7_idle");
        add_vec(0, 1, 3'd6, 8'h11, mk(1, 1, 0, 6'b001100, 8'h00, 8'h00), "mvaz_t0");
        add_vec(0, 1, 3'd1, 8'h22, mk(0, 0, 0, 6'b000000, 8'h00, 8'h00), "mvaz_busy_start");
        add_vec(0, 0, 3'd0, 8'h00, mk(0, 0, 0, 6'b000000, 8'h00, 8'h00), "mvaz_no_second");
        add_vec(0, 1, 3'd5, 8'h80, mk(1, 0, 0, 6'b010001, 8'h80, 8'h00), "addibb_t0");
        add_vec(0, 0, 3'd0, 8'h00, mk(1, 1, 0, 6'b001010, 8'h00, 8'h00), "addibb_t1");
        add_vec(0, 0, 3'd0, 8'h00, mk(0, 0, 0, 6'b000000, 8'h00, 8'h00), "addibb_idle");
        add_vec(0, 1, 3'd0, 8'hAA, mk(1, 1, 0, 6'b000000, 8'h00, 8'h00), "nop_t0");
        add_vec(0, 0, 3'd0, 8'h00, mk(0, 0, 0, 6'b000000, 8'h00, 8'h00), "nop_idle");

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].st, vecs[i].op, vecs[i].imm);
            check(vecs[i].name, vecs[i].exp);
        end

        model_edge(1'b1, 1'b0, 3'd0, 8'h00, e);
        drive(1'b1, 1'b0, 3'd0, 8'h00);
        check("rand_reset", e);

        for (int k = 0; k < 600; k++) begin
            r_clr = ($urandom_range(0, 39) == 0);
            r_st  = 1'($urandom_range(0, 1));
            r_op  = 3'($urandom_range(0, 7));
            r_imm = 8'($urandom);
            model_edge(r_clr, r_st, r_op, r_imm, e);
            drive(r_clr, r_st, r_op, r_imm);
            check("rand_step", e);
            n_checks++;
            if (($countones({RAout, RBout, RZout}) > 1) ||
                (RAout && RAin) || (RBout && RBin) || (RZout && RZin)) begin
                n_fail++;
                $display("FAIL bus_invariant: got out=%b%b%b in=%b%b%b required one driver, no self-load",
                         RAout, RBout, RZout, RAin, RBin, RZin);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tutorial_control_unit.md
Name: tutorial_control_unit

Overview:
Hardwired micro-sequencer for the tutorial DataPath (registers A, B, Z, adder with immediate). It accepts one macro-instruction at a time over a start/busy handshake and expands it into a registered sequence of one-hot bus-drive and register-load controls (T-steps). It replaces hand-driven control stimulus and sits directly between an instruction source and the DataPath control inputs.

Parameters:
IMM_W, 8, width of immediate field and of AddImmediate/RegisterAImmediate outputs
OP_W, 3, opcode width

Ports:
clock  in  1  system clock, all state updates on rising edge
clear  in  1  synchronous active-high reset
start  in  1  request to execute instr_op/instr_imm; accepted only when busy=0
instr_op  in  OP_W  opcode (encoding below)
instr_imm  in  IMM_W  immediate operand
busy  out  1  high from acceptance cycle+1 until done cycle inclusive
done  out  1  one-cycle pulse in final T-step of a legal instruction
err  out  1  one-cycle pulse when an illegal opcode is accepted
RAout, RBout, RZout  out  1 each  bus drive enables (at most one high)
RAin, RBin, RZin  out  1 each  register load enables
AddImmediate  out  IMM_W  adder immediate operand
RegisterAImmediate  out  IMM_W  immediate load value for A

Behaviour:
- Reset: clear=1 at a rising edge forces state IDLE; busy, done, err, all enables 0; both immediate outputs 0. Applies mid-operation: the in-flight instruction is abandoned, no done, no further steps.
- Opcodes: 000 NOP; 001 LDI_A (A<=imm); 010 ADDI_B_A (B<=A+imm); 011 MV_B_Z (B<=Z); 100 ADDI_A_A (A<=A+imm); 101 ADDI_B_B (B<=B+imm); 110 MV_A_Z (A<=Z); 111 illegal.
- Acceptance: at an edge with start=1, busy=0, clear=0, op and imm are latched; the first T-step is visible in the following cycle. start while busy=1 is ignored (not queued).
- States: IDLE, T0, T1, ERR. IDLE -> T0 on accept (legal op), IDLE -> ERR on op 111. T0 -> T1 for two-step ops, T0 -> IDLE for one-step ops. T1 -> IDLE. ERR -> IDLE.
- Step contents (all outputs registered, held for exactly one full cycle):
  NOP T0: no enables, done=1.
  LDI_A T0: RegisterAImmediate=imm, RAin=1, done=1.
  ADDI_x_y T0: Ryout=1, AddImmediate=imm, RZin=1. T1: RZout=1, Rxin=1, done=1.
  MV_x_Z T0: RZout=1, Rxin=1, done=1.
- ERR: err=1 for one cycle, busy=1, no enables, no done.
- Immediate outputs are 0 in every step that does not use them; enables not listed are 0.
- Invariant: at most one of RAout/RBout/RZout high in any cycle; a register is never both driving and loading in the same step.
- Back-to-back: in the done (or err) cycle busy=1, so a start there is ignored; next accept earliest in the following IDLE cycle. Throughput: 1-step op every 2 cycles, 2-step op every 3 cycles.
- Latency: accept edge -> first step 1 cycle; done in cycle 1 (1-step) or 2 (2-step) after accept.
- Immediate arithmetic/width is owned by DataPath; unit passes imm unmodified.

Decomposition:
- Shared package tutorial_ctrl_pkg: opcode localparams, state encoding, IMM_W/OP_W defaults, a control-word bundle (6 enables + 2 immediates).
- One natural sub-module: tutorial_step_decode (pure combinational: latched op, imm, state -> control word); top holds FSM, latch, output registers.

Test Plan:
- Reset then LDI_A imm=5 -> cycle after accept: RegisterAImmediate=8'h05, RAin=1, done=1; following cycle all 0, busy=0.
- ADDI_B_A imm=5 after LDI_A 5 -> T0: RAout=1, AddImmediate=8'h05, RZin=1; T1: RZout=1, RBin=1, done=1; DataPath B reads 8'h0A.
- start asserted continuously with ops LDI_A 3 then MV_B_Z -> second op accepted only after busy drops; no overlap, one-hot bus every cycle.
- op 111 imm=8'hFF -> err pulse one cycle, all enables and immediates 0, no done, busy for one cycle.
- clear asserted during T0 of ADDI_A_A -> next cycle IDLE, all outputs 0, no T1, no done; subsequent LDI_A 7 executes normally.
- start with busy=1 during MV_A_Z step -> ignored; no second done, latched op unchanged.
